// File: rtl/bcd_digit_counter_pkg.sv
// Shared definitions for the BCD digit counter: digit limit, FSM encoding and
// the trigger priority helper (lowest set bit wins).
package bcd_digit_counter_pkg;

    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam int         MAX_DIGITS = 9;

    typedef enum logic {
        IDLE   = 1'b0,
        RIPPLE = 1'b1
    } state_t;

    // Scans from the top down so the lowest asserted bit is the last to win.
    function automatic logic [3:0] lowest_set_index(input logic [MAX_DIGITS-1:0] trig);
        logic [3:0] result;
        result = 4'd0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (trig[i]) result = 4'(i);
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// Single BCD digit incrementer: 9 wraps to 0 with carry out, otherwise +1.
// Uses an explicit compare against 9 so a digit can never reach 10..15.
module bcd_digit_step
    import bcd_digit_counter_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       inc,
    output logic [3:0] next_digit,
    output logic       carry
);

    logic at_max;

    assign at_max = (digit == BCD_MAX);
    assign carry  = inc & at_max;

    always_comb begin
        next_digit = digit;
        if (inc) begin
            next_digit = at_max ? 4'd0 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/bcd_digit_counter.sv
// Packed-BCD counter: adds 10^i per inc_clk (i = lowest trigger bit), carry
// ripples one digit per clock; ref_clk snapshots the count for display.
// Optional macro BCD_SATURATE_EN: hold at all-9s instead of wrapping.
//
// state  | meaning
// IDLE   | waiting for inc_clk; ref_clk snapshots immediately
// RIPPLE | stepping digit idx; carry moves idx up one digit per clock
module bcd_digit_counter
    import bcd_digit_counter_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIGITS-1:0]     trigger,
    input  logic                  inc_clk,
    input  logic                  ref_clk,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   disp_bcd,
    output logic                  disp_valid,
    output logic                  busy,
    output logic                  overflow
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("bcd_digit_counter: DIGITS must be in 1..9");
    end

    state_t                state, state_nx;
    logic [4*DIGITS-1:0]   count, count_nx;
    logic [IW-1:0]         idx, idx_nx;
    logic                  ovf_nx;
    logic                  ref_pend, ref_pend_nx;
    logic                  snap;
    logic [4*DIGITS-1:0]   snap_val;
    logic [3:0]            cur_digit;
    logic [3:0]            step_digit;
    logic                  step_inc;
    logic                  step_carry;
    logic [3:0]            low_idx;

    assign low_idx = lowest_set_index(MAX_DIGITS'(trigger));

    always_comb begin
        cur_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) cur_digit = count[4*i +: 4];
        end
    end

    bcd_digit_step u_step (
        .digit      (cur_digit),
        .inc        (step_inc),
        .next_digit (step_digit),
        .carry      (step_carry)
    );

`ifdef BCD_SATURATE_EN
    // True when every digit from idx upward is 9, i.e. the carry would leave the top.
    logic sat;
    always_comb begin
        sat = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) >= idx && count[4*i +: 4] != BCD_MAX) sat = 1'b0;
        end
    end
`endif

    always_comb begin
        state_nx    = state;
        count_nx    = count;
        idx_nx      = idx;
        ovf_nx      = overflow;
        ref_pend_nx = ref_pend;
        snap        = 1'b0;
        step_inc    = 1'b0;

        case (state)
            IDLE: begin
                snap = ref_clk;
                if (clr) begin
                    count_nx = '0;
                    ovf_nx   = 1'b0;
                end else if (inc_clk && (trigger != '0)) begin
                    idx_nx   = IW'(low_idx);
                    state_nx = RIPPLE;
                end
            end

            RIPPLE: begin
                if (clr) begin
                    state_nx = IDLE;
                    count_nx = '0;
                end else begin
`ifdef BCD_SATURATE_EN
                    if (sat) begin
                        ovf_nx   = 1'b1;
                        state_nx = IDLE;
                    end else
`endif
                    begin
                        step_inc = 1'b1;
                        for (int i = 0; i < DIGITS; i++) begin
                            if (idx == IW'(i)) count_nx[4*i +: 4] = step_digit;
                        end
                        if (!step_carry) begin
                            state_nx = IDLE;
                        end else if (idx == IW'(DIGITS - 1)) begin
                            ovf_nx   = 1'b1;
                            state_nx = IDLE;
                        end else begin
                            idx_nx = idx + IW'(1);
                        end
                    end
                end

                // A deferred refresh is served on the exit edge with the final value.
                if (state_nx == IDLE) begin
                    snap        = ref_pend | ref_clk;
                    ref_pend_nx = 1'b0;
                end else if (ref_clk) begin
                    ref_pend_nx = 1'b1;
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    // Completed ripples show the post-ripple count; any clear shows the pre-clear count.
    assign snap_val = (state == RIPPLE && !clr) ? count_nx : count;
    assign busy     = (state == RIPPLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            idx        <= '0;
            overflow   <= 1'b0;
            ref_pend   <= 1'b0;
            disp_bcd   <= '0;
            disp_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            count      <= count_nx;
            idx        <= idx_nx;
            overflow   <= ovf_nx;
            ref_pend   <= ref_pend_nx;
            disp_valid <= snap;
            if (snap) disp_bcd <= snap_val;
        end
    end

endmodule

// File: tb/tb_bcd_digit_counter.sv
// Self-checking bench for bcd_digit_counter: decimal-arithmetic reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_bcd_digit_counter;

    localparam int DIGITS = 8;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [DIGITS-1:0]   trigger = '0;
    logic                inc_clk = 1'b0;
    logic                ref_clk = 1'b0;
    logic                clr = 1'b0;
    logic [4*DIGITS-1:0] disp_bcd;
    logic                disp_valid;
    logic                busy;
    logic                overflow;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_digit_counter #(.DIGITS(DIGITS)) dut (
        .clk        (clk),
        .reset      (reset),
        .trigger    (trigger),
        .inc_clk    (inc_clk),
        .ref_clk    (ref_clk),
        .clr        (clr),
        .disp_bcd   (disp_bcd),
        .disp_valid (disp_valid),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic longint pow10(input int e);
        longint r = 1;
        for (int k = 0; k < e; k++) r = r * 10;
        return r;
    endfunction

    function automatic int digit_of(input longint v, input int j);
        return int'((v / pow10(j)) % 10);
    endfunction

    function automatic logic [4*DIGITS-1:0] to_bcd(input longint v);
        logic [4*DIGITS-1:0] r;
        longint t = v;
        r = '0;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: count as a plain decimal number, ripple as a latency.
    longint m_count = 0, m_result = 0, m_disp = 0;
    int     m_left = 0;
    bit     m_res_ovf = 0, m_ovf = 0, m_valid = 0, m_pend = 0, m_known = 1;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_count = 0; m_left = 0; m_disp = 0; m_valid = 0;
            m_ovf = 0; m_pend = 0; m_known = 1;
        end else begin
            m_valid = 0;
            if (m_left == 0) begin
                if (ref_clk) begin
                    m_disp = m_count; m_known = 1; m_valid = 1;
                end
                if (clr) begin
                    m_count = 0; m_ovf = 0;
                end else if (inc_clk && trigger != '0) begin
                    int i, j;
                    i = 0;
                    while (!trigger[i]) i++;
                    j = i;
                    while (j < DIGITS && digit_of(m_count, j) == 9) j++;
                    if (j == DIGITS) begin
`ifdef BCD_SATURATE_EN
                        m_result = m_count; m_left = 1;
`else
                        m_result = m_count % pow10(i); m_left = DIGITS - i;
`endif
                        m_res_ovf = 1;
                    end else begin
                        m_result = m_count + pow10(i); m_left = j - i + 1; m_res_ovf = 0;
                    end
                end
            end else if (clr) begin
                m_left = 0; m_count = 0;
                if (ref_clk || m_pend) begin
                    m_known = 0; m_valid = 1;
                end
                m_pend = 0;
            end else begin
                if (ref_clk) m_pend = 1;
                m_left--;
                if (m_left == 0) begin
                    m_count = m_result;
                    if (m_res_ovf) m_ovf = 1;
                    if (m_pend) begin
                        m_disp = m_count; m_known = 1; m_valid = 1; m_pend = 0;
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            check("busy", busy, (m_left > 0));
            check("overflow", overflow, m_ovf);
            check("disp_valid", disp_valid, m_valid);
            if (m_known) check("disp_bcd", disp_bcd, to_bcd(m_disp));
        end
    end

    task automatic pulse_inc(input int bitpos);
        trigger = '0;
        trigger[bitpos] = 1'b1;
        inc_clk = 1'b1;
        @(negedge clk);
        inc_clk = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 30) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic refresh();
        ref_clk = 1'b1;
        @(negedge clk);
        ref_clk = 1'b0;
    endtask

    // Builds a BCD value from zero with non-carrying single-digit increments.
    task automatic load(input logic [4*DIGITS-1:0] val);
        logic [4*DIGITS-1:0] v;
        v = val;
        do_clr();
        for (int j = 0; j < DIGITS; j++) begin
            for (int r = 0; r < int'(v[4*j +: 4]); r++) begin
                pulse_inc(j);
                wait_idle();
            end
        end
        trigger = '0;
    endtask

    initial begin
        int nb, pulses;
        logic [4*DIGITS-1:0] cap;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_disp", disp_bcd, 0);
        check("reset_busy", busy, 0);
        check("reset_ovf", overflow, 0);
        check("reset_valid", disp_valid, 0);

        // Single increment at digit 0
        pulse_inc(0);
        count_busy(nb);
        check("busy_len_1", nb, 1);
        refresh();
        check("disp_one", disp_bcd, 32'h0000_0001);
        check("valid_one", disp_valid, 1);

        // trigger == 0 does nothing
        trigger = '0;
        inc_clk = 1'b1;
        @(negedge clk);
        inc_clk = 1'b0;
        check("no_trig_busy", busy, 0);

        // 999 + 1 ripples across four digits
        load(32'h0000_0999);
        pulse_inc(0);
        count_busy(nb);
        check("busy_len_999", nb, 4);
        refresh();
        check("disp_1000", disp_bcd, 32'h0000_1000);
        check("ovf_1000", overflow, 0);

        // Full-scale increment
        load(32'h9999_9999);
        pulse_inc(0);
        count_busy(nb);
        refresh();
`ifdef BCD_SATURATE_EN
        check("busy_len_sat", nb, 1);
        check("disp_sat", disp_bcd, 32'h9999_9999);
`else
        check("busy_len_wrap", nb, 8);
        check("disp_wrap", disp_bcd, 32'h0000_0000);
`endif
        check("ovf_full", overflow, 1);
        do_clr();
        check("ovf_cleared", overflow, 0);

        // Lowest trigger bit wins; a second inc while busy is ignored
        trigger = 8'b0001_0100;
        inc_clk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        inc_clk = 1'b0;
        wait_idle();
        refresh();
        check("disp_100", disp_bcd, 32'h0000_0100);

        // Refresh requested mid-ripple is served on ripple exit
        load(32'h0000_0099);
        pulse_inc(0);
        refresh();
        pulses = 0;
        cap = '0;
        for (int c = 0; c < 8; c++) begin
            if (disp_valid) begin
                pulses++;
                cap = disp_bcd;
            end
            @(negedge clk);
        end
        check("deferred_pulses", pulses, 1);
        check("deferred_disp", cap, 32'h0000_0100);

        // Clear aborts a ripple
        load(32'h0000_9999);
        pulse_inc(0);
        do_clr();
        check("abort_busy", busy, 0);
        repeat (3) @(negedge clk);
        refresh();
        check("abort_disp", disp_bcd, 32'h0000_0000);
        check("abort_ovf", overflow, 0);

        // Refresh and clear together: snapshot sees the pre-clear count
        load(32'h0000_0042);
        ref_clk = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        ref_clk = 1'b0;
        clr = 1'b0;
        check("refclr_disp", disp_bcd, 32'h0000_0042);
        refresh();
        check("refclr_after", disp_bcd, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
